// File: rtl/lab3_cache_mem_responder.sv
// Memory-side responder for the lab3 cache refill/evict port: word-array backing store, fixed latency, one request outstanding.
// Optional LAB3_MEM_RAND_DELAY_EN adds 0..3 LFSR-chosen cycles to each request's wait time.
module lab3_cache_mem_responder #(
    parameter int p_num_words = 256,
    parameter int p_latency   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg,
    output logic [1:0]  state_dbg
);

    // Handshake: a transfer happens on a rising edge where both val and rdy are 1.
    // val never waits on rdy, and a message is held stable while val=1 and rdy=0.
    // memreq_msg  = {type_[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
    // memresp_msg = {type_[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}

    localparam int c_idx_w = $clog2(p_num_words);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [4:0]  load;
    logic [2:0]  r_type;
    logic [7:0]  r_opaque;
    logic [1:0]  r_len;
    logic [31:0] r_data;
    logic [31:0] mem [p_num_words];

    logic [2:0]         req_type;
    logic [7:0]         req_opaque;
    logic [c_idx_w-1:0] req_idx;
    logic [1:0]         req_off;
    logic [1:0]         req_len;
    logic [31:0]        req_data;
    logic               is_rd;
    logic               is_wr;
    logic               accept;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               unused_addr_hi;

    assign req_type       = memreq_msg[76:74];
    assign req_opaque     = memreq_msg[73:66];
    assign req_idx        = memreq_msg[36 +: c_idx_w];
    assign req_off        = memreq_msg[35:34];
    assign req_len        = memreq_msg[33:32];
    assign req_data       = memreq_msg[31:0];
    assign unused_addr_hi = ^memreq_msg[65:36+c_idx_w];

    assign is_rd  = (req_type == 3'd0);
    assign is_wr  = (req_type == 3'd1) || (req_type == 3'd2);
    assign accept = memreq_val && memreq_rdy;

    // Subword writes shift the low bytes to the offset; bytes pushed past byte 3 fall off.
    always_comb begin
        be    = 4'hf;
        wdata = req_data;
        if (req_len != 2'd0) begin
            be    = 4'((5'd1 << req_len) - 5'd1) << req_off;
            wdata = req_data << {req_off, 3'b000};
        end
    end

`ifdef LAB3_MEM_RAND_DELAY_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 4'b0001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign load = 5'(p_latency - 1) + {3'b000, lfsr[1:0]};
`else
    assign load = 5'(p_latency - 1);
`endif

    // Backing store is deliberately left unreset; the harness fills it with INIT requests.
    always_ff @(posedge clk) begin
        if (accept && is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[req_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            r_type   <= 3'd0;
            r_opaque <= 8'd0;
            r_len    <= 2'd0;
            r_data   <= 32'd0;
        end else if (accept) begin
            // Read data is captured now, so later writes cannot change this response.
            r_type   <= req_type;
            r_opaque <= req_opaque;
            r_len    <= req_len;
            r_data   <= is_rd ? mem[req_idx] : 32'd0;
            cnt      <= load;
            state    <= (load == 5'd0) ? RESP : WAIT;
        end else begin
            case (state)
                WAIT: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (memresp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign memresp_val = (state == RESP);
    assign memreq_rdy  = reset && ((state == IDLE) || ((state == RESP) && memresp_rdy));
    assign memresp_msg = {r_type, r_opaque, 2'b00, r_len, r_data};
    assign state_dbg   = state;

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Bench for lab3_cache_mem_responder: a latency-2 and a latency-1 instance checked every cycle against a behavioural memory model.
module tb_lab3_cache_mem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam logic [2:0] T_RD   = 3'd0;
    localparam logic [2:0] T_WR   = 3'd1;
    localparam logic [2:0] T_INIT = 3'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_val [2];
    logic        req_rdy [2];
    logic [76:0] req_msg [2];
    logic        resp_val [2];
    logic        resp_rdy [2];
    logic [46:0] resp_msg [2];
    logic [1:0]  st_dbg [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mdl_mem [2][256];
    logic [46:0] exp_msg [2];
    logic        pend [2];
    int          ready_cyc [2];
    logic        rand_bp [2];

    logic        mon_en = 1'b0;
    logic [46:0] obs_q [$];
    int          obs_cyc_q [$];

    lab3_cache_mem_responder #(.p_num_words(256), .p_latency(LAT0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
        .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0]),
        .state_dbg(st_dbg[0])
    );

    lab3_cache_mem_responder #(.p_num_words(256), .p_latency(LAT1)) dut1 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
        .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1]),
        .state_dbg(st_dbg[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [1:0] l, input logic [31:0] d);
        return {t, op, 2'b00, l, d};
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, k, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic exp_val(input int k);
        return pend[k] && (cyc >= ready_cyc[k]);
    endfunction

    task automatic model_accept(input int k, input logic [76:0] m);
        logic [2:0]  t;
        logic [31:0] d;
        logic [31:0] rd;
        int idx;
        int o;
        int n;
        t   = m[76:74];
        idx = int'(m[43:36]);
        o   = int'(m[35:34]);
        n   = int'(m[33:32]);
        d   = m[31:0];
        rd  = 32'd0;
        if (t == T_RD) begin
            rd = mdl_mem[k][idx];
        end else if (t == T_WR || t == T_INIT) begin
            for (int b = 0; b < 4; b++) begin
                if (n == 0) mdl_mem[k][idx][8*b +: 8] = d[8*b +: 8];
                else if (b >= o && b < o + n) mdl_mem[k][idx][8*b +: 8] = d[8*(b-o) +: 8];
            end
        end
        exp_msg[k]   = {t, m[73:66], 2'b00, m[33:32], rd};
        pend[k]      = 1'b1;
        ready_cyc[k] = cyc + lat_of(k);
    endtask

    always @(posedge clk) begin
        logic v;
        logic r;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                pend[k] = 1'b0;
            end else begin
                v = exp_val(k);
                r = !pend[k] || (v && resp_rdy[k]);
                if (v && resp_rdy[k]) pend[k] = 1'b0;
                if (req_val[k] && r) model_accept(k, req_msg[k]);
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic ev;
        logic er;
        for (int k = 0; k < 2; k++) begin
            ev = reset && exp_val(k);
            er = reset && (!pend[k] || (ev && resp_rdy[k]));
            chk("resp_val", k, 64'(resp_val[k]), 64'(ev));
            chk("req_rdy", k, 64'(req_rdy[k]), 64'(er));
            if (ev) chk("resp_msg", k, 64'(resp_msg[k]), 64'(exp_msg[k]));
        end
        if (mon_en && resp_val[1] && resp_rdy[1]) begin
            obs_q.push_back(resp_msg[1]);
            obs_cyc_q.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rand_bp[k]) resp_rdy[k] = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int k, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        bit done;
        done = 1'b0;
        req_msg[k] = {t, op, a, l, d};
        req_val[k] = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_rdy[k]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_val[k] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout dut%0d got=no_accept exp=accept", k);
        end
    endtask

    task automatic xact(input int k, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                        output logic [46:0] m, output int lat);
        int  ac;
        bit  got;
        got = 1'b0;
        m   = '0;
        lat = -1;
        resp_rdy[k] = 1'b1;
        send(k, t, op, a, l, d);
        ac = cyc;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (resp_val[k]) begin
                got = 1'b1;
                m   = resp_msg[k];
                lat = cyc - ac + 1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout dut%0d got=no_resp exp=resp", k);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [46:0] m;
        int          lat;
        int          nval;
        bit          got;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];

        b2b_addr = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0408, 32'h0000_000c};
        b2b_data = '{32'ha0a0_a0a0, 32'hb1b1_b1b1, 32'hc2c2_c2c2, 32'hd3d3_d3d3};
        for (int k = 0; k < 2; k++) begin
            req_val[k]   = 1'b0;
            req_msg[k]   = '0;
            resp_rdy[k]  = 1'b1;
            pend[k]      = 1'b0;
            ready_cyc[k] = 0;
            rand_bp[k]   = 1'b0;
        end

        // Reset: held low for 3 edges, ready must appear in the first cycle after release.
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 0, 64'(req_rdy[0]), 64'd1);
        chk("rdy_after_reset", 1, 64'(req_rdy[1]), 64'd1);
        @(posedge clk);
        #1;

        // Fill both backing stores, using aliased upper address bits.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 256; w++) begin
                send(k, T_INIT, 8'(w), (32'($urandom_range(0, 7)) << 10) | 32'(w << 2), 2'd0, $urandom);
            end
        end
        repeat (4) begin @(posedge clk); #1; end

        // Write then read.
        xact(0, T_INIT, 8'h01, 32'h100, 2'd0, 32'hdeadbeef, m, lat);
        chk("init_resp", 0, 64'(m), 64'(mk_resp(T_INIT, 8'h01, 2'd0, 32'h0)));
        chk("init_lat", 0, 64'(lat), 64'd2);
        xact(0, T_RD, 8'h02, 32'h100, 2'd0, 32'h0, m, lat);
        chk("read_resp", 0, 64'(m), 64'(mk_resp(T_RD, 8'h02, 2'd0, 32'hdeadbeef)));
        chk("read_lat", 0, 64'(lat), 64'd2);

        // Subword writes, including bytes that would cross the word boundary.
        xact(0, T_INIT, 8'h10, 32'h0, 2'd0, 32'h11223344, m, lat);
        xact(0, T_WR, 8'h11, 32'h1, 2'd2, 32'h0000aabb, m, lat);
        chk("wr_resp", 0, 64'(m), 64'(mk_resp(T_WR, 8'h11, 2'd2, 32'h0)));
        xact(0, T_RD, 8'h12, 32'h0, 2'd0, 32'h0, m, lat);
        chk("subword_read", 0, 64'(m[31:0]), 64'h11aabb44);
        xact(0, T_WR, 8'h13, 32'h3, 2'd3, 32'h00ccddee, m, lat);
        xact(0, T_RD, 8'h14, 32'h0, 2'd1, 32'h0, m, lat);
        chk("cross_word_read", 0, 64'(m), 64'(mk_resp(T_RD, 8'h14, 2'd1, 32'heeaabb44)));

        // Unknown type: echoed, data 0, no array access.
        xact(0, 3'd5, 8'h7e, 32'h100, 2'd0, 32'h12345678, m, lat);
        chk("other_resp", 0, 64'(m), 64'(mk_resp(3'd5, 8'h7e, 2'd0, 32'h0)));
        xact(0, T_RD, 8'h7f, 32'h100, 2'd0, 32'h0, m, lat);
        chk("other_noaccess", 0, 64'(m[31:0]), 64'hdeadbeef);

        // Backpressure: response held stable while the consumer stalls.
        resp_rdy[0] = 1'b0;
        send(0, T_RD, 8'h03, 32'h100, 2'd0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_val[0]) got = 1'b1;
        end
        chk("bp_arrive", 0, 64'(got), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_val", 0, 64'(resp_val[0]), 64'd1);
            chk("bp_msg", 0, 64'(resp_msg[0]), 64'(mk_resp(T_RD, 8'h03, 2'd0, 32'hdeadbeef)));
            chk("bp_rdy", 0, 64'(req_rdy[0]), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_val", 0, 64'(resp_val[0]), 64'd1);
        chk("bp_release_rdy", 0, 64'(req_rdy[0]), 64'd1);
        @(negedge clk);
        chk("bp_retired", 0, 64'(resp_val[0]), 64'd0);
        @(posedge clk);
        #1;

        // Reset while a read is waiting: the response must never appear.
        send(0, T_RD, 8'h44, 32'h100, 2'd0, 32'h0);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        nval = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_val[0]) nval++;
        end
        chk("dropped_resp_count", 0, 64'(nval), 64'd0);
        @(posedge clk);
        #1;
        xact(0, T_RD, 8'h45, 32'h100, 2'd0, 32'h0, m, lat);
        chk("post_reset_read", 0, 64'(m), 64'(mk_resp(T_RD, 8'h45, 2'd0, 32'hdeadbeef)));
        chk("post_reset_lat", 0, 64'(lat), 64'd2);

        // Back-to-back at latency 1, with an aliased address.
        for (int i = 0; i < 4; i++) begin
            xact(1, T_INIT, 8'(i), 32'(i * 4), 2'd0, b2b_data[i], m, lat);
        end
        chk("lat1", 1, 64'(lat), 64'd1);
        resp_rdy[1] = 1'b1;
        mon_en      = 1'b1;
        req_val[1]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_msg[1] = {T_RD, 8'(16 + i), b2b_addr[i], 2'd0, 32'h0};
            @(negedge clk);
            chk("b2b_rdy", 1, 64'(req_rdy[1]), 64'd1);
            @(posedge clk);
            #1;
        end
        req_val[1] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        chk("b2b_count", 1, 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_msg", 1, 64'(obs_q[i]), 64'(mk_resp(T_RD, 8'(16 + i), 2'd0, b2b_data[i])));
                if (i > 0) chk("b2b_spacing", 1, 64'(obs_cyc_q[i] - obs_cyc_q[i-1]), 64'd1);
            end
        end

        // Randomized traffic with random consumer backpressure.
        for (int k = 0; k < 2; k++) begin
            rand_bp[k] = 1'b1;
            for (int n = 0; n < 300; n++) begin
                send(k, 3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), $urandom,
                     2'($urandom_range(0, 3)), $urandom);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            rand_bp[k] = 1'b0;
            @(posedge clk);
            #1 resp_rdy[k] = 1'b1;
            repeat (20) begin @(posedge clk); #1; end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab3_cache_mem_responder.md
# lab3_cache_mem_responder

Memory-side responder for the cache's refill/evict port: accepts `mem_req_4B_t` requests from the cache controller's `cache_req_*` interface and returns `mem_resp_4B_t` responses on its `cache_resp_*` interface. It models main memory for lab3 cache integration tests. The backing store is a word array, access latency is fixed and parameterized, and one request is outstanding at a time. It is synthesizable and sits between the cache and the test harness.

## Interface
- `p_num_words`, 256: backing-store depth in 32-bit words; must be a power of 2.
- `p_latency`, 2: cycles from request acceptance to `memresp_val`; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memreq_val`  in  1  request valid (driven by the cache's `cache_req_val`).
- `memreq_rdy`  out  1  responder can accept a request.
- `memreq_msg`  in  `mem_req_4B_t`  fields: type_, opaque, addr, len, data.
- `memresp_val`  out  1  response valid.
- `memresp_rdy`  in  1  consumer accepts the response.
- `memresp_msg`  out  `mem_resp_4B_t`  fields: type_, opaque, test=0, len, data.

## Operation
- Word index is `addr[2 +: $clog2(p_num_words)]`. Upper address bits are ignored, so addresses wrap.
- READ: response data is the full stored word. Response `len` echoes the request `len`.
- WRITE and INIT:
  - `len`=0 writes all 4 bytes.
  - `len`=1..3 writes `len` bytes starting at byte offset `addr[1:0]`, taken from `data[8*len-1:0]`.
  - Bytes that would cross the word boundary are dropped.
  - Response data is 0.
- Any other type_: no array access; the response carries the echoed type_ and data 0.
- The response always echoes `type_` and `opaque`.
- The state machine has three states:
  - IDLE: `memreq_rdy`=1. On val&&rdy: latch type_/opaque/len, perform the array write or read-capture at that edge, load the counter with `p_latency-1`, then go to WAIT, or straight to RESP when `p_latency`=1.
  - WAIT: `memreq_rdy`=0. Decrement the counter each cycle and go to RESP when the counter reaches 1 (the cycle it would reach 0).
  - RESP: `memresp_val`=1 and `memresp_msg` is held stable.
    - `memreq_rdy`=`memresp_rdy`.
    - If `memresp_rdy` && `memreq_val`: retire the current response and accept the new request in the same cycle (back-to-back); next state follows the IDLE acceptance rule.
    - If `memresp_rdy` && !`memreq_val`: go to IDLE.
    - If !`memresp_rdy`: stay in RESP.
- Read data is captured at acceptance, so a later write cannot alter a pending read response.

## Timing
- Reset (`reset`=0, asynchronous):
  - state goes to IDLE, the counter to 0, and the latched response fields to 0.
  - `memresp_val`=0 and `memreq_rdy`=0 while reset is asserted.
  - After deassertion, `memreq_rdy`=1 from the first cycle.
  - Array contents are not reset; the bench initializes them with INIT.
- Reset mid-transaction drops the pending response. No response is ever issued for it.
- Latency: a request accepted at edge T gives `memresp_val`=1 in the cycle after edge T+`p_latency`-1, i.e. exactly `p_latency` cycles after acceptance.
- Throughput: 1 request per `p_latency` cycles with continuous `memresp_rdy` (back-to-back path). There is no combinational path from `memreq_val` to `memresp_val`.
- `memreq_rdy` depends combinationally on `memresp_rdy` only in RESP.

## Configuration
- `LAB3_MEM_RAND_DELAY_EN`
  - Defined: a 4-bit maximal-length LFSR (seed 4'b0001 on reset, advances every cycle) adds `lfsr[1:0]` extra cycles (0..3) to the WAIT duration of each request. The extra count is sampled at acceptance. This stresses the cache's counters and handshakes.
  - Undefined: no LFSR is instantiated, and latency is exactly `p_latency`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release → `memresp_val`=0 throughout reset; `memreq_rdy`=1 on the first cycle after release.
- **Write then read:** INIT addr 0x100, data 0xdeadbeef, len 0, opaque 0x01; then READ 0x100, opaque 0x02; `p_latency`=2 → responses {INIT, 0x01, data 0} then {READ, 0x02, data 0xdeadbeef}. Each `memresp_val` rises 2 cycles after acceptance.
- **Subword write:** INIT 0x0 = 0x11223344, then WRITE addr 0x1, len 2, data 0xaabb; READ 0x0 → 0x11aabb44.
- **Backpressure:** READ 0x100 with `memresp_rdy`=0 for 5 cycles → `memresp_val` and the message stay stable, `memreq_rdy`=0; one response issues on the `memresp_rdy` edge.
- **Back-to-back and wrap:** four READs with `memreq_val` and `memresp_rdy` held high, `p_latency`=1 → one response per cycle in order. Address `p_num_words*4` + 0x8 aliases to 0x8.
- **Reset mid-WAIT:** accept a READ, assert `reset` one cycle later → no response is ever produced; the next request completes normally.
